// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, FSM state and queue entry type for the instruction fetch unit
package ifu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory bus and core instruction handshake
interface instr_fetch_unit_if;
    import ifu_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_offset;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_offset
    );

endinterface

// File: rtl/ifu_queue.sv
// rtl/ifu_queue.sv - two-entry synchronous instruction queue with flush
module ifu_queue
    import ifu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  ifu_entry_t wdata,
    output ifu_entry_t head,
    output logic       full,
    output logic       empty
);

    ifu_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       do_push;
    logic       do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage and pointers; flush drops every entry and wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM, PC/redirect logic and queue; IFU_PERF_CNT_EN adds fetch_count
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'd0,
    parameter int              QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                reset,
`ifdef IFU_PERF_CNT_EN
    output logic [15:0]         fetch_count,
`endif
    instr_fetch_unit_if.master  bus
);

    localparam logic [1:0] QD = 2'(QDEPTH);

    ifu_state_t      state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] target_pc;
    logic            imem_req_q;
    logic [PC_W-1:0] imem_addr_q;

    ifu_entry_t      head;
    ifu_entry_t      wdata;
    logic            q_full;
    logic            q_empty;
    logic            hs;
    logic            redir;
    logic [PC_W-1:0] redir_target;
    logic            ack_req;
    logic            push;
    logic [1:0]      occ;
    logic [1:0]      occ_next;
    logic            space;

    assign hs    = ~q_empty & bus.instr_ready;
    assign redir = hs & bus.redirect;
    // Both operands are 8 bits, so the sign-extended add modulo 256 is a plain add.
    assign redir_target = head.pc + bus.redirect_offset;
    assign ack_req      = (state == REQ) & bus.imem_ack;
    assign push         = ack_req & ~redir;
    assign wdata        = '{pc: imem_addr_q, instr: bus.imem_rdata};

    // Occupancy after this cycle's push/pop decides whether another fetch fits.
    always_comb begin
        occ      = q_full ? 2'd2 : (q_empty ? 2'd0 : 2'd1);
        occ_next = occ + {1'b0, push} - {1'b0, hs};
        space    = (occ_next < QD);
    end

    ifu_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (hs),
        .flush (redir),
        .wdata (wdata),
        .head  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.instr_valid = ~q_empty;

    // Fetch FSM: one outstanding request, held stable until its ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            target_pc   <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redir) begin
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= redir_target;
                        fetch_pc    <= redir_target;
                        state       <= REQ;
                    end else if (space) begin
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (redir) begin
                        if (bus.imem_ack) begin
                            imem_addr_q <= redir_target;
                            fetch_pc    <= redir_target;
                        end else begin
                            target_pc <= redir_target;
                            state     <= FLUSH;
                        end
                    end else if (bus.imem_ack) begin
                        fetch_pc <= fetch_pc + 8'd1;
                        if (space) begin
                            imem_addr_q <= fetch_pc + 8'd1;
                        end else begin
                            imem_req_q <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.imem_ack) begin
                        imem_req_q <= 1'b0;
                        fetch_pc   <= target_pc;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Saturating count of instructions handed to the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= 16'd0;
        end else if (hs && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule
